// File: rtl/imem_sync.sv
// imem_sync: synchronous instruction memory with a valid/ready fetch port,
// a one-deep registered response, flush, run-time program load and a
// saturating fault counter. Sits between fetch PC logic and decode.
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | response register holds nothing (rsp_valid=0)
// S_FULL  | response register holds a result (rsp_valid=1)
module imem_sync #(
  parameter int              DEPTH    = 256,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013,
  localparam int             IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_instr,
  output logic [XLEN-1:0]  rsp_addr,
  output logic [1:0]       rsp_fault,
  input  logic             flush,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [XLEN-1:0]  ld_data,
  output logic [15:0]      fault_cnt
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  // Contents survive reset; only the elaboration-time fill and loads set them.
  logic [XLEN-1:0] mem [DEPTH] = '{default: NOP_WORD};

  state_t          state;
  logic            accept;
  logic            misaligned;
  logic            out_of_range;
  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] instr_nxt;
  logic [1:0]      fault_nxt;

  assign rsp_valid = (state == S_FULL);

  // A load owns the cycle, so a fetch can never see a half-written word.
  assign req_ready = !ld_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready && !flush;

  // The full word address is range-checked so high address bits never alias.
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign word_addr    = req_addr >> 2;
  assign out_of_range = (word_addr >= XLEN'(DEPTH));

  // Pick the fetched word or the fault substitute; misalignment wins.
  always_comb begin
    instr_nxt = mem[req_addr[IDX_W+1:2]];
    fault_nxt = FAULT_OK;
    if (misaligned) begin
      instr_nxt = NOP_WORD;
      fault_nxt = FAULT_ALIGN;
    end else if (out_of_range) begin
      instr_nxt = NOP_WORD;
      fault_nxt = FAULT_RANGE;
    end
  end

  // Program-load write port.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // Response register FSM with flush priority and the fault counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      rsp_instr <= NOP_WORD;
      rsp_addr  <= '0;
      rsp_fault <= FAULT_OK;
      fault_cnt <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state <= S_FULL;
          end
        end
        S_FULL: begin
          if (rsp_ready && !accept) begin
            state <= S_EMPTY;
          end
        end
        default: state <= S_EMPTY;
      endcase
      if (accept) begin
        rsp_instr <= instr_nxt;
        rsp_addr  <= req_addr;
        rsp_fault <= fault_nxt;
        if ((fault_nxt != FAULT_OK) && (fault_cnt != 16'hFFFF)) begin
          fault_cnt <= fault_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: a negedge monitor runs a reference model and response
// scoreboard for the whole run, while the main sequence applies a vector table
// and hand-written corner cases with direct checks.
module tb_imem_sync;

  localparam int          DEPTH = 256;
  localparam int          XLEN  = 32;
  localparam int          IDX_W = 8;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_instr;
  logic [XLEN-1:0]  rsp_addr;
  logic [1:0]       rsp_fault;
  logic             flush;
  logic             ld_en;
  logic [IDX_W-1:0] ld_idx;
  logic [XLEN-1:0]  ld_data;
  logic [15:0]      fault_cnt;

  imem_sync #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault), .flush(flush),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [15:0] model_fc = '0;
  logic        model_valid = 1'b0;
  logic        prev_hold = 1'b0;
  rsp_t        prev_rsp;
  rsp_t        mon_e;
  logic        mon_acc;

  initial foreach (model_mem[i]) model_mem[i] = NOP;

  function automatic rsp_t model(input logic [31:0] a);
    rsp_t r;
    r.addr = a;
    if (a[1:0] != 2'b00) begin
      r.instr = NOP;
      r.fault = 2'b01;
    end else if ((a >> 2) >= 32'(DEPTH)) begin
      r.instr = NOP;
      r.fault = 2'b10;
    end else begin
      r.instr = model_mem[a[9:2]];
      r.fault = 2'b00;
    end
    return r;
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_fc    = '0;
      model_valid = 1'b0;
      prev_hold   = 1'b0;
    end else begin
      check("m_rsp_valid", rsp_valid, model_valid);
      check("m_req_ready", req_ready, !ld_en && (!model_valid || rsp_ready));
      check("m_fault_cnt", fault_cnt, model_fc);
      if (prev_hold) begin
        check("hold_instr", rsp_instr, prev_rsp.instr);
        check("hold_addr", rsp_addr, prev_rsp.addr);
        check("hold_fault", rsp_fault, prev_rsp.fault);
      end
      if (model_valid && (rsp_ready || flush)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: response at %0t with no expected entry", $time);
        end else begin
          mon_e = sb_q.pop_front();
          if (rsp_ready) begin
            check("sb_instr", rsp_instr, mon_e.instr);
            check("sb_addr", rsp_addr, mon_e.addr);
            check("sb_fault", rsp_fault, mon_e.fault);
          end
        end
      end
      mon_acc = req_valid && !ld_en && (!model_valid || rsp_ready) && !flush;
      prev_hold = model_valid && !rsp_ready && !flush;
      prev_rsp.instr = rsp_instr;
      prev_rsp.addr  = rsp_addr;
      prev_rsp.fault = rsp_fault;
      if (mon_acc) begin
        mon_e = model(req_addr);
        sb_q.push_back(mon_e);
        if (mon_e.fault != 2'b00 && model_fc != 16'hFFFF) model_fc = model_fc + 16'd1;
      end
      if (ld_en) model_mem[ld_idx] = ld_data;
      if (flush)        model_valid = 1'b0;
      else if (mon_acc) model_valid = 1'b1;
      else if (rsp_ready) model_valid = 1'b0;
    end
  end

  typedef struct {
    bit          ld;
    logic [7:0]  idx;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
    logic [15:0] exp_fc;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0000, NOP,          2'b00, 16'd0};
    vt[1]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0004, NOP,          2'b00, 16'd0};
    vt[2]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0008, NOP,          2'b00, 16'd0};
    vt[3]  = '{1'b1, 8'd1,   32'h00100093, 32'h0000_0004, 32'h0,        2'b00, 16'd0};
    vt[4]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0004, 32'h00100093, 2'b00, 16'd0};
    vt[5]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0006, NOP,          2'b01, 16'd1};
    vt[6]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0400, NOP,          2'b10, 16'd2};
    vt[7]  = '{1'b0, 8'd0,   32'h0,        32'h0000_0402, NOP,          2'b01, 16'd3};
    vt[8]  = '{1'b0, 8'd0,   32'h0,        32'h0000_03FC, NOP,          2'b00, 16'd3};
    vt[9]  = '{1'b1, 8'd255, 32'hDEADBEEF, 32'h0000_03FC, 32'h0,        2'b00, 16'd3};
    vt[10] = '{1'b0, 8'd0,   32'h0,        32'h0000_03FC, 32'hDEADBEEF, 2'b00, 16'd3};
    vt[11] = '{1'b0, 8'd0,   32'h0,        32'h8000_0004, NOP,          2'b10, 16'd4};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    repeat (2) tick();
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_instr", rsp_instr, NOP);
    check("rst_addr", rsp_addr, 32'h0);
    check("rst_fault", rsp_fault, 2'b00);
    check("rst_fcnt", fault_cnt, 16'h0);
    rst = 1'b0;

    // Vector table: back-to-back fetches and loads, one response per cycle.
    for (int i = 0; i < NV; i++) begin
      req_valid = 1'b1;
      req_addr  = vt[i].addr;
      ld_en     = vt[i].ld;
      ld_idx    = vt[i].idx;
      ld_data   = vt[i].data;
      if (vt[i].ld) begin
        #1;
        check($sformatf("v%0d_ld_ready", i), req_ready, 1'b0);
        tick();
      end else begin
        tick();
        check($sformatf("v%0d_valid", i), rsp_valid, 1'b1);
        check($sformatf("v%0d_instr", i), rsp_instr, vt[i].exp_instr);
        check($sformatf("v%0d_addr", i), rsp_addr, vt[i].addr);
        check($sformatf("v%0d_fault", i), rsp_fault, vt[i].exp_fault);
        check($sformatf("v%0d_fcnt", i), fault_cnt, vt[i].exp_fc);
      end
    end
    ld_en = 1'b0;
    req_valid = 1'b0;
    tick();

    // Backpressure: held response stays put, then hands over with no bubble.
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", req_ready, 1'b0);
      tick();
      check("bp_instr", rsp_instr, 32'h00100093);
      check("bp_addr", rsp_addr, 32'h4);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_switch_valid", rsp_valid, 1'b1);
    check("bp_switch_addr", rsp_addr, 32'h8);
    req_valid = 1'b0;
    tick();

    // Flush while FULL with a same-cycle request, then a faulted request under flush.
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    flush = 1'b1; req_addr = 32'hC;
    tick();
    check("fl_valid", rsp_valid, 1'b0);
    check("fl_addr_kept", rsp_addr, 32'h0);
    check("fl_fcnt", fault_cnt, 16'd4);
    req_addr = 32'h7;
    tick();
    check("fl2_valid", rsp_valid, 1'b0);
    check("fl2_fcnt", fault_cnt, 16'd4);
    flush = 1'b0; req_valid = 1'b0;
    tick();
    check("fl_idle_valid", rsp_valid, 1'b0);

    // Asynchronous reset mid-stream clears the response before the next edge.
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    check("ar_pre_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b0; req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_valid", rsp_valid, 1'b0);
    check("ar_instr", rsp_instr, NOP);
    check("ar_fcnt", fault_cnt, 16'h0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    check("ar_keep1", rsp_instr, 32'h00100093);
    req_addr = 32'h3FC;
    tick();
    check("ar_keep255", rsp_instr, 32'hDEADBEEF);

    // Saturation of the fault counter.
    req_addr = 32'h1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", fault_cnt, 16'hFFFE);
    tick();
    check("sat_ffff", fault_cnt, 16'hFFFF);
    tick();
    check("sat_hold", fault_cnt, 16'hFFFF);
    check("sat_fault", rsp_fault, 2'b01);
    req_valid = 1'b0;
    repeat (3) tick();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Parametrised, synchronous instruction memory, the next generation of the core's combinational fetch ROM. It holds DEPTH words, pre-filled with NOP at elaboration, and is loaded at run time through a write port. Fetches use a valid/ready request/response handshake with a registered one-cycle read, backpressure, flush and fault reporting. It sits between the fetch stage PC logic and the decode pipeline register.

Parameters:
- DEPTH, 256, number of instruction words; power of two, minimum 4.
- XLEN, 32, instruction and address width.
- NOP_WORD, 32'h00000013, fill word and the word returned on faulted fetches.
- IDX_W, $clog2(DEPTH), word-index width. Derived; not to be overridden.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous reset, active-high.
- req_valid, input, 1: fetch request present.
- req_ready, output, 1: block can accept a fetch this cycle.
- req_addr, input, XLEN: byte address of the fetch.
- rsp_valid, output, 1: response register holds a valid result.
- rsp_ready, input, 1: consumer takes the response this cycle.
- rsp_instr, output, XLEN: fetched instruction word.
- rsp_addr, output, XLEN: byte address that produced rsp_instr.
- rsp_fault, output, 2: 00 ok, 01 misaligned, 10 out of range.
- flush, input, 1: discard the pending response and any same-cycle request.
- ld_en, input, 1: program-load write strobe.
- ld_idx, input, IDX_W: word index to write.
- ld_data, input, XLEN: word to write.
- fault_cnt, output, 16: saturating count of faulted responses produced.

Behaviour:
- Reset (asynchronous assert): rsp_valid=0, rsp_instr=NOP_WORD, rsp_addr=0, rsp_fault=00, fault_cnt=0. Memory contents are not cleared by reset; they hold the elaboration-time NOP fill plus any loaded words. Reset deassertion is synchronous to clk.
- req_ready = !ld_en && (!rsp_valid || rsp_ready). This is combinational and never depends on req_valid.
- Accept occurs when req_valid && req_ready && !flush. On the next edge:
  - rsp_valid=1 and rsp_addr=req_addr.
  - rsp_instr and rsp_fault are set as follows, in priority order:
    - req_addr[1:0] != 0: NOP_WORD, fault 01.
    - req_addr >> 2 >= DEPTH: NOP_WORD, fault 10.
    - otherwise: mem[req_addr[IDX_W+1:2]], fault 00.
- Latency is exactly one cycle from accept to rsp_valid. Back-to-back accepts give one response per cycle while rsp_ready is held at 1.
- Response register states:
  - EMPTY (rsp_valid=0): accept moves it to FULL.
  - FULL (rsp_valid=1):
    - rsp_ready && accept: stays FULL and loads the new word.
    - rsp_ready && !accept: moves to EMPTY.
    - !rsp_ready: holds rsp_instr, rsp_addr and rsp_fault stable.
- Flush has priority over everything except reset. At the next edge rsp_valid=0 and the same-cycle request is dropped; req_ready still reads its formula value, but no accept happens. rsp_instr, rsp_addr and rsp_fault keep their old values.
- Load: when ld_en=1, mem[ld_idx] <= ld_data at the edge. req_ready is 0 that cycle, so a load and a fetch never collide. A fetch of that word accepted in the following cycle returns the new data.
- ld_en while FULL does not disturb the held response; it reflects pre-load data.
- fault_cnt increments by 1 on each accept with a non-zero fault and saturates at 16'hFFFF. Flushed requests are not counted.
- Upper address bits above IDX_W+2 take part only in the range check, never in indexing. No wrap-around aliasing.

Test Plan:
- Reset, then fetch addresses 0x0, 0x4, 0x8 back-to-back with rsp_ready=1 -> rsp_valid high from cycle 1; rsp_instr=0x00000013 each cycle; rsp_addr tracks 0x0, 0x4, 0x8; fault 00.
- ld_idx=1, ld_data=0x00100093 in cycle 0 (req_ready=0 that cycle), then fetch 0x4 -> rsp_instr=0x00100093 one cycle after accept.
- Fetch 0x6 -> NOP_WORD, fault 01, fault_cnt=1. Then fetch 0x400 with DEPTH=256 -> NOP_WORD, fault 10, fault_cnt=2. Then fetch 0x402 -> fault 01 (misaligned wins).
- Backpressure:
  - Fetch 0x4 with rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_instr/rsp_addr stable for those cycles.
  - rsp_ready=1 with req_valid=1 at 0x8 -> response switches to 0x8 with no bubble.
- Flush while FULL with a simultaneous request to 0xC -> next cycle rsp_valid=0, no response for 0xC, fault_cnt unchanged.
- Assert rst asynchronously mid-stream with rsp_valid=1 -> rsp_valid=0 immediately, before the next edge. Loaded words still read back after reset. Force fault_cnt to 0xFFFF, then issue a faulted fetch -> it stays 0xFFFF.
